kb_entry_ctrl: RTL

Sequences PS/2 scan-code bytes from the keyboard receiver into 32-bit hexadecimal operands for the CPU's input path. Opens an entry window on a CPU read request, tracks make/break prefixes, edits the accumulated digits (append, backspace, clear), and hands the finished value to the CPU through a valid/ack handshake. Sits between the keyboard receiver and the CPU I/O read port, and also drives the live entry value to the seven-segment display.

---
 rtl/kb_entry_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/kb_entry_ctrl.sv
// Keyboard operand entry: turns PS/2 make/break scan codes into 32-bit hex operands
// handed to the CPU over a valid/ack handshake, with a live display value.
module kb_entry_ctrl #(
    parameter int unsigned MAX_DIGITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  kb_code,
    input  logic        kb_valid,
    input  logic        rd_req,
    input  logic        rd_ack,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        busy,
    output logic [31:0] entry_val,
    output logic [3:0]  entry_cnt
);

    localparam int unsigned CODE_W = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned NIB_W  = 4;

    localparam logic [CNT_W-1:0]  MAX_CNT  = CNT_W'(MAX_DIGITS);
    localparam logic [CODE_W-1:0] KC_EXT   = 8'hE0;
    localparam logic [CODE_W-1:0] KC_BREAK = 8'hF0;
    localparam logic [CODE_W-1:0] KC_ENTER = 8'h5A;
    localparam logic [CODE_W-1:0] KC_BKSP  = 8'h66;
    localparam logic [CODE_W-1:0] KC_ESC   = 8'h76;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_brk;
    logic                w_brk_nxt;
    logic                w_make;
    logic                w_is_hex;
    logic [NIB_W-1:0]    w_nib;
    logic                w_enter_ok;

    logic [DATA_W-1:0]   r_val;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_rd_data;
    logic                r_rd_valid;
    logic                r_busy;
    logic [DATA_W-1:0]   w_val_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [DATA_W-1:0]   w_rd_data_nxt;
    logic                w_rd_valid_nxt;
    logic                w_busy_nxt;

    // Scan code set 2 to hex nibble; bit 4 flags a hex key.
    function automatic logic [NIB_W:0] hex_decode(input logic [CODE_W-1:0] code);
        logic [NIB_W:0] res;
        res = '0;
        case (code)
            8'h45: res = {1'b1, 4'h0};
            8'h16: res = {1'b1, 4'h1};
            8'h1E: res = {1'b1, 4'h2};
            8'h26: res = {1'b1, 4'h3};
            8'h25: res = {1'b1, 4'h4};
            8'h2E: res = {1'b1, 4'h5};
            8'h36: res = {1'b1, 4'h6};
            8'h3D: res = {1'b1, 4'h7};
            8'h3E: res = {1'b1, 4'h8};
            8'h46: res = {1'b1, 4'h9};
            8'h1C: res = {1'b1, 4'hA};
            8'h32: res = {1'b1, 4'hB};
            8'h21: res = {1'b1, 4'hC};
            8'h23: res = {1'b1, 4'hD};
            8'h24: res = {1'b1, 4'hE};
            8'h2B: res = {1'b1, 4'hF};
            default: res = '0;
        endcase
        return res;
    endfunction

    assign {w_is_hex, w_nib} = hex_decode(kb_code);

    // Prefix tracking is state-independent so a release can straddle transactions.
    always_comb begin
        w_brk_nxt = r_brk;
        w_make    = 1'b0;
        if (kb_valid && (kb_code != KC_EXT)) begin
            if (kb_code == KC_BREAK) begin
                w_brk_nxt = 1'b1;
            end else if (r_brk) begin
                w_brk_nxt = 1'b0;
            end else begin
                w_make = 1'b1;
            end
        end
    end

    assign w_enter_ok = w_make && (kb_code == KC_ENTER) && (r_cnt != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (rd_req)     w_state_nxt = ST_COLLECT;
            ST_COLLECT: if (w_enter_ok) w_state_nxt = ST_DONE;
            ST_DONE:    if (rd_ack)     w_state_nxt = ST_IDLE;
            default:                    w_state_nxt = ST_IDLE;
        endcase
    end

    // Next values for the registered datapath and outputs.
    always_comb begin
        w_val_nxt      = r_val;
        w_cnt_nxt      = r_cnt;
        w_rd_data_nxt  = r_rd_data;
        w_rd_valid_nxt = r_rd_valid;
        w_busy_nxt     = (w_state_nxt == ST_COLLECT);
        case (r_state)
            ST_IDLE: begin
                if (rd_req) begin
                    w_val_nxt = '0;
                    w_cnt_nxt = '0;
                end
            end
            ST_COLLECT: begin
                if (w_make) begin
                    if (w_is_hex) begin
                        if (r_cnt < MAX_CNT) begin
                            w_val_nxt = {r_val[DATA_W-NIB_W-1:0], w_nib};
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end else if (kb_code == KC_BKSP) begin
                        if (r_cnt != '0) begin
                            w_val_nxt = r_val >> NIB_W;
                            w_cnt_nxt = r_cnt - CNT_W'(1);
                        end
                    end else if (kb_code == KC_ESC) begin
                        w_val_nxt = '0;
                        w_cnt_nxt = '0;
                    end else if (w_enter_ok) begin
                        w_rd_data_nxt  = r_val;
                        w_rd_valid_nxt = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (rd_ack) begin
                    w_rd_valid_nxt = 1'b0;
                    w_val_nxt      = '0;
                    w_cnt_nxt      = '0;
                end
            end
            default: begin
                w_rd_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_brk      <= 1'b0;
            r_val      <= '0;
            r_cnt      <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_brk      <= w_brk_nxt;
            r_val      <= w_val_nxt;
            r_cnt      <= w_cnt_nxt;
            r_rd_data  <= w_rd_data_nxt;
            r_rd_valid <= w_rd_valid_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign busy      = r_busy;
    assign entry_val = r_val;
    assign entry_cnt = r_cnt;

endmodule
